mem_fifo_loader: RTL and testbench

MEM_FIFO_LOADER -- requirements
Module: mem_fifo_loader

---
 rtl/minilab_pkg.sv | 15 +
 rtl/word_unpacker.sv | 45 ++++
 rtl/mem_fifo_loader.sv | 130 +++++++++++++
 tb/tb_mem_fifo_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minilab_pkg.sv
// Shared sizing constants and the loader FSM state type for the matrix-loader slice.
package minilab_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int MATRIX_COLUMNS_A = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        PUSH,
        DONE
    } loader_state_t;

endpackage

// File: rtl/word_unpacker.sv
// Holds one captured memory word and walks it out one lane at a time, lane 0 first.
module word_unpacker #(
    parameter int DATA_WIDTH = minilab_pkg::DATA_WIDTH,
    parameter int LANES      = minilab_pkg::MATRIX_COLUMNS_A
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [DATA_WIDTH*LANES-1:0] word,
    input  logic                        advance,
    output logic [DATA_WIDTH-1:0]       byte_out,
    output logic                        last_byte
);

    localparam int IW = $clog2(LANES);
    localparam int CW = IW + 1;

    logic [DATA_WIDTH*LANES-1:0] capture_reg;
    logic [CW-1:0]               byte_cnt_reg;
    logic [DATA_WIDTH-1:0]       lanes [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lanes[gi] = capture_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The counter is one bit wider than the lane index so it parks at LANES
    // after the final lane instead of wrapping back to 0 mid-load.
    assign byte_out  = lanes[byte_cnt_reg[IW-1:0]];
    assign last_byte = (byte_cnt_reg == CW'(LANES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_reg  <= '0;
            byte_cnt_reg <= '0;
        end else if (load) begin
            capture_reg  <= word;
            byte_cnt_reg <= '0;
        end else if (advance) begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_fifo_loader.sv
// Reads the B vector and the A rows from memory, one word at a time, and scatters
// each word byte-by-byte into the B FIFO or the matching A-row FIFO.
module mem_fifo_loader #(
    parameter int          DATA_WIDTH       = minilab_pkg::DATA_WIDTH,
    parameter int          MATRIX_COLUMNS_A = minilab_pkg::MATRIX_COLUMNS_A,
    parameter logic [31:0] BASE_ADDR        = 32'h0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [31:0]                 address,
    output logic                        read,
    input  logic [63:0]                 readdata,
    input  logic                        readdatavalid,
    input  logic                        waitrequest,
    output logic [DATA_WIDTH-1:0]       fifo_data,
    output logic [MATRIX_COLUMNS_A-1:0] wrreq_A,
    output logic                        wrreq_B,
    input  logic [MATRIX_COLUMNS_A-1:0] wrfull_A,
    input  logic                        wrfull_B,
    output logic                        busy,
    output logic                        done
);

    import minilab_pkg::*;

    localparam logic [3:0] LAST_ROW = 4'(MATRIX_COLUMNS_A);

    loader_state_t state_reg;
    logic [3:0]    row_cnt_reg;
    logic [31:0]   address_reg;
    logic          read_reg;
    logic          busy_reg;
    logic          done_reg;

    logic target_full;
    logic push_ok;
    logic last_byte;

    // Row 0 is the B vector; row k (1..N) feeds A FIFO k-1.
    always_comb begin
        target_full = wrfull_B;
        for (int i = 0; i < MATRIX_COLUMNS_A; i++) begin
            if (row_cnt_reg == 4'(i + 1)) begin
                target_full = wrfull_A[i];
            end
        end
    end

    assign push_ok = (state_reg == PUSH) && !target_full;
    assign wrreq_B = push_ok && (row_cnt_reg == 4'd0);

    generate
        for (genvar gi = 0; gi < MATRIX_COLUMNS_A; gi++) begin : g_wrreq
            assign wrreq_A[gi] = push_ok && (row_cnt_reg == 4'(gi + 1));
        end
    endgenerate

    word_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (MATRIX_COLUMNS_A)
    ) u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      ((state_reg == WAIT_DATA) && readdatavalid),
        .word      (readdata),
        .advance   (push_ok),
        .byte_out  (fifo_data),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            row_cnt_reg <= '0;
            address_reg <= '0;
            read_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= REQ;
                        row_cnt_reg <= '0;
                        address_reg <= BASE_ADDR;
                        read_reg    <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                REQ: begin
                    if (!waitrequest) begin
                        read_reg  <= 1'b0;
                        state_reg <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (readdatavalid) begin
                        state_reg <= PUSH;
                    end
                end
                PUSH: begin
                    if (push_ok && last_byte) begin
                        if (row_cnt_reg == LAST_ROW) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            row_cnt_reg <= row_cnt_reg + 4'd1;
                            address_reg <= BASE_ADDR + 32'(row_cnt_reg + 4'd1);
                            read_reg    <= 1'b1;
                            state_reg   <= REQ;
                        end
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign address = address_reg;
    assign read    = read_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_mem_fifo_loader.sv
// Directed bench: memory responder, FIFO write logger, and a linear sequence of load scenarios.
module tb_mem_fifo_loader;

    localparam logic [31:0] BASE = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] address;
    logic        read;
    logic [63:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic        waitrequest = 1'b0;
    logic [7:0]  fifo_data;
    logic [7:0]  wrreq_A;
    logic        wrreq_B;
    logic [7:0]  wrfull_A = '0;
    logic        wrfull_B = 1'b0;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    bit wait_armed = 1'b0;
    bit ramp_row0  = 1'b0;
    int clr_gen    = 0;

    int         seen_gen = 0;
    int         cnt_b = 0;
    int         cnt_a [8];
    logic [7:0] got_b [16];
    logic [7:0] got_a [8][16];
    int         reads = 0;
    int         done_cnt = 0;
    int         wait_cycles = 0;
    int         wait_bad = 0;
    int         multi_hot = 0;

    mem_fifo_loader #(
        .DATA_WIDTH       (8),
        .MATRIX_COLUMNS_A (8),
        .BASE_ADDR        (BASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .address       (address),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .fifo_data     (fifo_data),
        .wrreq_A       (wrreq_A),
        .wrreq_B       (wrreq_B),
        .wrfull_A      (wrfull_A),
        .wrfull_B      (wrfull_B),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [31:0] n;
        n = a - BASE;
        if (ramp_row0 && n == 32'd0) return 64'h0706050403020100;
        return {8{n[7:0]}};
    endfunction

    // Zero-wait memory: data one cycle after acceptance; optional 3-cycle stall on row 4.
    always begin : responder
        logic        acc;
        logic [31:0] a;
        int          wait_used;
        @(negedge clk);
        acc = rst_n && read && !waitrequest;
        a   = address;
        @(posedge clk);
        #1;
        readdatavalid = acc;
        readdata      = acc ? mem_word(a) : 64'h0;
        if (!wait_armed) wait_used = 0;
        if (wait_armed && wait_used < 3 && read && address == BASE + 32'd4) begin
            waitrequest = 1'b1;
            wait_used++;
        end else begin
            waitrequest = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (clr_gen != seen_gen) begin
            seen_gen    <= clr_gen;
            cnt_b       <= 0;
            for (int k = 0; k < 8; k++) cnt_a[k] <= 0;
            reads       <= 0;
            done_cnt    <= 0;
            wait_cycles <= 0;
            wait_bad    <= 0;
            multi_hot   <= 0;
        end else begin
            if (wrreq_B) begin
                if (cnt_b < 16) got_b[cnt_b] <= fifo_data;
                cnt_b <= cnt_b + 1;
            end
            for (int k = 0; k < 8; k++) begin
                if (wrreq_A[k]) begin
                    if (cnt_a[k] < 16) got_a[k][cnt_a[k]] <= fifo_data;
                    cnt_a[k] <= cnt_a[k] + 1;
                end
            end
            if ($countones({wrreq_A, wrreq_B}) > 1) multi_hot <= multi_hot + 1;
            if (read && !waitrequest) reads <= reads + 1;
            if (read && waitrequest) begin
                wait_cycles <= wait_cycles + 1;
                if (address !== BASE + 32'd4) wait_bad <= wait_bad + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        clr_gen++;
        tick();
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_read"}, 64'(read), 64'd0);
        chk({tag, "_address"}, 64'(address), 64'd0);
        chk({tag, "_wrreq_A"}, 64'(wrreq_A), 64'd0);
        chk({tag, "_wrreq_B"}, 64'(wrreq_B), 64'd0);
        chk({tag, "_fifo_data"}, 64'(fifo_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Pulses start at cycle 0 and returns the cycle on which done is seen.
    task automatic run_load(input int restart_at, input bit stall_en, output int cyc);
        int stall_cnt;
        bit stalling;
        bit stalled;
        stall_cnt = 0;
        stalling  = 1'b0;
        stalled   = 1'b0;
        start = 1'b1;
        cyc   = 0;
        do begin
            tick();
            cyc++;
            start = (cyc == restart_at);
            if (cyc == 1) chk("read_at_cycle1", 64'(read), 64'd1);
            if (stalling) begin
                stall_cnt++;
                chk($sformatf("stall_wrreq_A_c%0d", stall_cnt), 64'(wrreq_A), 64'd0);
                chk($sformatf("stall_wrreq_B_c%0d", stall_cnt), 64'(wrreq_B), 64'd0);
                if (stall_cnt == 5) begin
                    wrfull_A[2] = 1'b0;
                    stalling    = 1'b0;
                end
            end else if (stall_en && !stalled && cnt_a[2] == 3) begin
                wrfull_A[2] = 1'b1;
                stalling    = 1'b1;
                stalled     = 1'b1;
            end
        end while (!done && cyc < 400);
        start = 1'b0;
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_data(input bit ramp, input string tag);
        chk({tag, "_B_count"}, 64'(cnt_b), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_B_byte%0d", tag, i), 64'(got_b[i]), ramp ? 64'(i) : 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_A%0d_count", tag, k), 64'(cnt_a[k]), 64'd8);
            for (int i = 0; i < 8; i++)
                chk($sformatf("%s_A%0d_byte%0d", tag, k, i), 64'(got_a[k][i]), 64'(k + 1));
        end
        chk({tag, "_multi_hot"}, 64'(multi_hot), 64'd0);
    endtask

    initial begin
        int cyc;
        int guard;

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();

        // Plain load with a second start mid-load that must be ignored.
        run_load(20, 1'b0, cyc);
        chk("t1_done_cycle", 64'(cyc), 64'd91);
        tick();
        tick();
        chk("t1_done_pulses", 64'(done_cnt), 64'd1);
        chk("t1_reads", 64'(reads), 64'd9);
        chk("t1_busy_after", 64'(busy), 64'd0);
        check_data(1'b0, "t1");
        $display("[TB] load 1 (zero wait, ignored restart) done at cycle %0d", cyc);

        // Waitrequest on row 4 plus a 5-cycle full stall on A FIFO 2.
        clear_log();
        wait_armed = 1'b1;
        run_load(0, 1'b1, cyc);
        wait_armed = 1'b0;
        chk("t2_done_cycle", 64'(cyc), 64'd99);
        chk("t2_wait_cycles", 64'(wait_cycles), 64'd3);
        chk("t2_wait_addr_bad", 64'(wait_bad), 64'd0);
        check_data(1'b0, "t2");
        $display("[TB] load 2 (waitrequest + full stall) done at cycle %0d", cyc);

        // Byte order on row 0.
        clear_log();
        ramp_row0 = 1'b1;
        run_load(0, 1'b0, cyc);
        ramp_row0 = 1'b0;
        check_data(1'b1, "t3");
        $display("[TB] load 3 (row 0 byte ramp) done at cycle %0d", cyc);

        // Reset in the middle of row 5, then a clean reload.
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (cnt_a[4] != 3 && guard < 200) begin
            tick();
            guard++;
        end
        chk("t4_reached_row5", 64'(cnt_a[4]), 64'd3);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("t4_midreset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t4_idle_busy", 64'(busy), 64'd0);
        chk("t4_idle_read", 64'(read), 64'd0);
        clear_log();
        run_load(0, 1'b0, cyc);
        chk("t4_done_cycle", 64'(cyc), 64'd91);
        check_data(1'b0, "t4");
        $display("[TB] load 4 (after mid-load reset) done at cycle %0d", cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
